vector_commit_stage: RTL and testbench

- Commit stage directly downstream of the vector execution stage (logic/shift units).
- Accepts per-cycle execution results (destination register, 64-bit data, byte enables) over a valid/ready handshake.
- Buffers results in an in-order FIFO and drains them to the vector register file write port over a second valid/ready handshake.
- Optional bypass lookup lets the register-read stage source in-flight results that are not yet written.

---
 rtl/vector_commit_stage_if.sv | 24 ++
 rtl/vector_commit_stage.sv | 135 +++++++++++++
 tb/tb_vector_commit_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_commit_stage_if.sv
// vector_commit_stage_if
//   One valid/ready channel that carries a vector register write: destination
//   register, data and byte enables. The commit stage uses one instance as its
//   execution-result input and a second one as its register-file write output.
//   Ports (signals):
//     valid  producer -> consumer  entry valid
//     ready  consumer -> producer  consumer accepts the entry
//     addr   producer -> consumer  vector register index (ADDR_W)
//     data   producer -> consumer  register data (DATA_W)
//     be     producer -> consumer  byte enables (DATA_W/8)
//   Modports: master drives valid/addr/data/be; slave drives ready.
interface vector_commit_stage_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   be;

  modport master (output valid, addr, data, be, input ready);
  modport slave  (input valid, addr, data, be, output ready);
endinterface

// File: rtl/vector_commit_stage.sv
// vector_commit_stage
//   In-order commit buffer between the vector execution stage and the vector
//   register file write port. Results are accepted on the ex channel, held in a
//   DEPTH-entry ring buffer and drained, oldest first, on the wr channel.
//   Optional bypass search (macro VECTOR_COMMIT_BYPASS_EN) lets the register
//   read stage pick up the youngest in-flight result for a register.
//   Ports:
//     clock         rising-edge clock
//     reset_n       asynchronous active-low reset
//     flush         synchronous flush; drops every held entry
//     ex            slave channel: execution results in (ex_valid/ex_ready/...)
//     wr            master channel: register file write out (wr_valid/...)
//     byp_addr      bypass query register
//     byp_hit       query matches a held entry
//     byp_data      data of youngest matching entry (0 on miss)
//     byp_be        byte enables of youngest matching entry (0 on miss)
//     commit_count  completed writes, wraps at 2^CNT_W
//     occupancy     entries held
module vector_commit_stage #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  vector_commit_stage_if.slave     ex,
  vector_commit_stage_if.master    wr,
  input  logic [ADDR_W-1:0]        byp_addr,
  output logic                     byp_hit,
  output logic [DATA_W-1:0]        byp_data,
  output logic [DATA_W/8-1:0]      byp_be,
  output logic [CNT_W-1:0]         commit_count,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Both handshake flags come from registered occupancy only, so a pop on a
  // full buffer does not open a slot in the same cycle.
  assign ex.ready = (occupancy != FULL);
  assign wr.valid = (occupancy != '0);
  assign push     = ex.valid && ex.ready;
  assign pop      = wr.valid && wr.ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      commit_count <= '0;
      valid_q      <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      valid_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
        commit_count    <= commit_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Payload storage carries no reset; valid_q alone qualifies its contents.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      addr_q[wr_ptr] <= ex.addr;
      data_q[wr_ptr] <= ex.data;
      be_q[wr_ptr]   <= ex.be;
    end
  end

  // Head entry straight from storage; zero while the buffer is empty.
  always_comb begin
    wr.addr = '0;
    wr.data = '0;
    wr.be   = '0;
    if (valid_q[rd_ptr]) begin
      wr.addr = addr_q[rd_ptr];
      wr.data = data_q[rd_ptr];
      wr.be   = be_q[rd_ptr];
    end
  end

`ifdef VECTOR_COMMIT_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Walk oldest to youngest from the read pointer; the last match wins, which
  // is the entry closest to the write pointer.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_be   = '0;
    byp_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr + PTR_W'(i);
      if (valid_q[byp_idx] && (addr_q[byp_idx] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = data_q[byp_idx];
        byp_be   = be_q[byp_idx];
      end
    end
  end
`else
  logic unused_byp_addr;

  assign byp_hit         = 1'b0;
  assign byp_data        = '0;
  assign byp_be          = '0;
  assign unused_byp_addr = ^byp_addr;
`endif
endmodule

// File: tb/tb_vector_commit_stage.sv
// tb_vector_commit_stage
//   Self-checking bench for vector_commit_stage. A queue-based reference model
//   tracks held results and the commit count; each scenario task drives the
//   DUT and compares its outputs against the model or fixed expectations.
//   Honours VECTOR_COMMIT_BYPASS_EN the same way the design does.
module tb_vector_commit_stage;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
`ifdef VECTOR_COMMIT_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } entry_t;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              flush    = 1'b0;
  logic [ADDR_W-1:0] byp_addr = '0;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [BE_W-1:0]   byp_be;
  logic [CNT_W-1:0]  commit_count;
  logic [OCC_W-1:0]  occupancy;

  vector_commit_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ex_if ();
  vector_commit_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  vector_commit_stage #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .ex(ex_if.slave), .wr(wr_if.master),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data), .byp_be(byp_be),
    .commit_count(commit_count), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model
  entry_t      mq[$];
  int unsigned m_count = 0;
  bit          m_pushed = 1'b0;

  function automatic void model_reset();
    mq.delete();
    m_count = 0;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  function automatic void model_edge();
    entry_t e;
    bit     do_push;
    bit     do_pop;
    do_push  = ex_if.valid && (mq.size() != DEPTH);
    do_pop   = (mq.size() != 0) && wr_if.ready;
    m_pushed = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        mq.delete(0);
        m_count = (m_count + 1) % (1 << CNT_W);
      end
      if (do_push) begin
        e.addr = ex_if.addr;
        e.data = ex_if.data;
        e.be   = ex_if.be;
        mq.push_back(e);
        m_pushed = 1'b1;
      end
    end
  endfunction

  function automatic entry_t model_head();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  function automatic bit model_byp(input logic [ADDR_W-1:0] a, output entry_t e);
    bit found = 1'b0;
    e = '0;
    for (int j = mq.size() - 1; j >= 0 && !found; j--) begin
      if (mq[j].addr == a) begin
        e     = mq[j];
        found = 1'b1;
      end
    end
    if (!BYP_ON) e = '0;
    return BYP_ON && found;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_idle();
    ex_if.valid = 1'b0;
    ex_if.addr  = '0;
    ex_if.data  = '0;
    ex_if.be    = '0;
    wr_if.ready = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drive_push(input int unsigned a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    ex_if.valid = 1'b1;
    ex_if.addr  = ADDR_W'(a);
    ex_if.data  = d;
    ex_if.be    = b;
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({wr_if.valid, byp_hit, ex_if.ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags got %b want 001", {wr_if.valid, byp_hit, ex_if.ready});
    end
    checks++;
    if (occupancy !== '0 || commit_count !== '0) begin
      errors++; $display("FAIL reset_counts got occ=%0d cnt=%0d want 0/0", occupancy, commit_count);
    end
    checks++;
    if ({wr_if.addr, wr_if.data, wr_if.be, byp_data, byp_be} !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h data=%h be=%h byp=%h/%h want 0",
                         wr_if.addr, wr_if.data, wr_if.be, byp_data, byp_be);
    end
    reset_n = 1'b1;
    model_reset();
    // One committed write, then three held entries before reset hits.
    wr_if.ready = 1'b1;
    drive_push(2, 64'h1111, 8'hFF);
    tick();
    ex_if.valid = 1'b0;
    tick();
    wr_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(10 + i, {$urandom, $urandom}, 8'($urandom));
      tick();
    end
    ex_if.valid = 1'b0;
    checks++;
    if (occupancy !== 3'd3 || commit_count !== 16'd1) begin
      errors++; $display("FAIL pre_reset got occ=%0d cnt=%0d want 3/1", occupancy, commit_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({wr_if.valid, ex_if.ready} !== 2'b01 || occupancy !== '0 || commit_count !== '0) begin
      errors++; $display("FAIL async_reset got valid=%b ready=%b occ=%0d cnt=%0d want 0/1/0/0",
                         wr_if.valid, ex_if.ready, occupancy, commit_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    wr_if.ready = 1'b1;
    drive_push(3, 64'h0123456789ABCDEF, 8'hFF);
    checks++;
    if (wr_if.valid !== 1'b0) begin
      errors++; $display("FAIL no_cut_through got wr_valid=%b want 0", wr_if.valid);
    end
    tick();
    ex_if.valid = 1'b0;
    checks++;
    if ({wr_if.valid, wr_if.addr, wr_if.data, wr_if.be} !== {1'b1, 5'd3, 64'h0123456789ABCDEF, 8'hFF}) begin
      errors++; $display("FAIL single_write got v=%b a=%0d d=%h be=%h want 1/3/0123456789abcdef/ff",
                         wr_if.valid, wr_if.addr, wr_if.data, wr_if.be);
    end
    tick();
    checks++;
    if (commit_count !== 16'd1 || occupancy !== '0 || wr_if.valid !== 1'b0) begin
      errors++; $display("FAIL single_commit got cnt=%0d occ=%0d v=%b want 1/0/0",
                         commit_count, occupancy, wr_if.valid);
    end
  endtask

  task automatic test_backpressure();
    int unsigned drained = 0;
    wr_if.ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_push(i, {$urandom, $urandom}, 8'($urandom));
      if (i == 5) begin
        checks++;
        if (ex_if.ready !== 1'b0 || occupancy !== 3'd4) begin
          errors++; $display("FAIL full_ready got ready=%b occ=%0d want 0/4", ex_if.ready, occupancy);
        end
      end
      tick();
    end
    checks++;
    if (occupancy !== 3'd4 || wr_if.addr !== 5'd1) begin
      errors++; $display("FAIL fifth_held got occ=%0d head=%0d want 4/1", occupancy, wr_if.addr);
    end
    wr_if.ready = 1'b1;
    while (drained < 5) begin
      checks++;
      if (wr_if.valid !== 1'b1 || wr_if.addr !== ADDR_W'(drained + 1) || ex_if.ready !== (mq.size() != DEPTH)) begin
        errors++; $display("FAIL drain_order got v=%b addr=%0d rdy=%b want 1/%0d/%b",
                           wr_if.valid, wr_if.addr, ex_if.ready, drained + 1, mq.size() != DEPTH);
      end
      tick();
      if (m_pushed) ex_if.valid = 1'b0;
      drained++;
    end
    checks++;
    if (occupancy !== '0 || commit_count !== CNT_W'(m_count)) begin
      errors++; $display("FAIL drain_end got occ=%0d cnt=%0d want 0/%0d", occupancy, commit_count, m_count);
    end
    wr_if.ready = 1'b0;
  endtask

  task automatic test_bypass();
    wr_if.ready = 1'b0;
    drive_push(7, 64'hAA, 8'hFF); tick();
    drive_push(9, 64'hCC, 8'h0F); tick();
    drive_push(7, 64'hBB, 8'hF0); tick();
    ex_if.valid = 1'b0;
    byp_addr = 5'd7;
    #1;
    checks++;
    if ({byp_hit, byp_data, byp_be} !== (BYP_ON ? {1'b1, 64'hBB, 8'hF0} : 73'd0)) begin
      errors++; $display("FAIL byp_youngest got hit=%b data=%h be=%h want %b/%h/%h",
                         byp_hit, byp_data, byp_be, BYP_ON, BYP_ON ? 64'hBB : 64'h0, BYP_ON ? 8'hF0 : 8'h0);
    end
    byp_addr = 5'd8;
    drive_push(8, 64'hDD, 8'h3C);
    #1;
    checks++;
    if ({byp_hit, byp_data, byp_be} !== 73'd0) begin
      errors++; $display("FAIL byp_miss got hit=%b data=%h be=%h want 0/0/0", byp_hit, byp_data, byp_be);
    end
    tick();
    ex_if.valid = 1'b0;
    checks++;
    if ({byp_hit, byp_data, byp_be} !== (BYP_ON ? {1'b1, 64'hDD, 8'h3C} : 73'd0)) begin
      errors++; $display("FAIL byp_after_push got hit=%b data=%h be=%h want %b", byp_hit, byp_data, byp_be, BYP_ON);
    end
    wr_if.ready = 1'b1;
    for (int i = 0; i < 8 && mq.size() != 0; i++) tick();
    checks++;
    if (occupancy !== '0) begin
      errors++; $display("FAIL byp_drain got occ=%0d want 0", occupancy);
    end
    wr_if.ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] saved;
    wr_if.ready = 1'b0;
    drive_push(4, 64'h44, 8'h00); tick();
    drive_push(5, 64'h55, 8'h01); tick();
    saved = CNT_W'(m_count);
    flush = 1'b1;
    wr_if.ready = 1'b1;
    drive_push(6, 64'h66, 8'hFF);
    tick();
    flush = 1'b0;
    ex_if.valid = 1'b0;
    checks++;
    if (occupancy !== '0 || wr_if.valid !== 1'b0 || commit_count !== saved) begin
      errors++; $display("FAIL flush got occ=%0d v=%b cnt=%0d want 0/0/%0d", occupancy, wr_if.valid, commit_count, saved);
    end
    // Zero byte enables still commit.
    drive_push(12, 64'hFEED, 8'h00);
    tick();
    ex_if.valid = 1'b0;
    checks++;
    if ({wr_if.valid, wr_if.addr, wr_if.be} !== {1'b1, 5'd12, 8'h00}) begin
      errors++; $display("FAIL zero_be got v=%b a=%0d be=%h want 1/12/00", wr_if.valid, wr_if.addr, wr_if.be);
    end
    tick();
    checks++;
    if (commit_count !== saved + 1'b1) begin
      errors++; $display("FAIL zero_be_commit got cnt=%0d want %0d", commit_count, saved + 1'b1);
    end
    wr_if.ready = 1'b0;
  endtask

  task automatic test_random();
    entry_t exp_h;
    entry_t exp_b;
    bit     exp_hit;
    for (int c = 0; c < 600; c++) begin
      exp_h   = model_head();
      exp_hit = model_byp(byp_addr, exp_b);
      checks++;
      if (wr_if.valid !== (mq.size() != 0) || ex_if.ready !== (mq.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_flags c=%0d got v=%b rdy=%b want size=%0d", c, wr_if.valid, ex_if.ready, mq.size());
      end
      checks++;
      if (occupancy !== OCC_W'(mq.size()) || commit_count !== CNT_W'(m_count)) begin
        errors++; $display("FAIL rnd_counts c=%0d got occ=%0d cnt=%0d want %0d/%0d",
                           c, occupancy, commit_count, mq.size(), m_count);
      end
      checks++;
      if ({wr_if.addr, wr_if.data, wr_if.be} !== exp_h) begin
        errors++; $display("FAIL rnd_head c=%0d got %h want %h", c, {wr_if.addr, wr_if.data, wr_if.be}, exp_h);
      end
      checks++;
      if ({byp_hit, byp_data, byp_be} !== {exp_hit, exp_b.data, exp_b.be}) begin
        errors++; $display("FAIL rnd_byp c=%0d q=%0d got %b/%h/%h want %b/%h/%h",
                           c, byp_addr, byp_hit, byp_data, byp_be, exp_hit, exp_b.data, exp_b.be);
      end
      ex_if.valid = ($urandom_range(0, 3) != 0);
      ex_if.addr  = ADDR_W'($urandom_range(0, 7));
      ex_if.data  = {$urandom, $urandom};
      ex_if.be    = 8'($urandom);
      wr_if.ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      byp_addr    = ADDR_W'($urandom_range(0, 7));
      tick();
    end
    drive_idle();
  endtask

  task automatic test_count_wrap();
    int unsigned guard = 0;
    drive_push(1, 64'h1, 8'h1);
    wr_if.ready = 1'b1;
    while (m_count != (1 << CNT_W) - 1 && guard < 70000) begin
      tick();
      guard++;
    end
    ex_if.valid = 1'b0;
    checks++;
    if (commit_count !== 16'hFFFF || wr_if.valid !== 1'b1) begin
      errors++; $display("FAIL count_max got cnt=%h v=%b want ffff/1 (guard %0d)", commit_count, wr_if.valid, guard);
    end
    tick();
    checks++;
    if (commit_count !== 16'h0000) begin
      errors++; $display("FAIL count_wrap got cnt=%h want 0000", commit_count);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bypass();
    test_flush();
    test_random();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
